// File: rtl/bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// master identifiers and default bus widths.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. The pointer register lives in the parent;
// this block only turns the requests and the last winner into a one-hot grant.
module rr_arb2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // On a tie the master that did not win last time goes first.
  always_comb begin
    if (req == 2'b11) begin
      win = (last == M1) ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the fetch unit (m0) and load/store unit (m1),
// one outstanding access at a time, with round-robin tie breaking.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rest,

  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  output logic            m0_gnt_o,
  output logic            m0_rvalid_o,
  output logic [DW-1:0]   m0_rdata_o,

  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  input  logic [DW/8-1:0] m1_be_i,
  output logic            m1_gnt_o,
  output logic            m1_rvalid_o,
  output logic [DW-1:0]   m1_rdata_o,

  output logic            s_req_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  output logic [DW/8-1:0] s_be_o,
  input  logic            s_gnt_i,
  input  logic            s_rvalid_i,
  input  logic [DW-1:0]   s_rdata_i
);

  state_t     state;
  logic       last;
  logic [1:0] win;
  logic       busy_m0;
  logic       busy_m1;
  logic       free;
  logic       issue;

  rr_arb2 u_rr_arb2 (
    .req  ({m1_req_i, m0_req_i}),
    .last (last),
    .win  (win)
  );

  assign busy_m0 = (state == BUSY_M0);
  assign busy_m1 = (state == BUSY_M1);

  // The slot frees up in the response cycle, which is what allows one access
  // per cycle against a single-cycle memory. Nothing is issued while in reset.
  assign free  = !(busy_m0 || busy_m1) || s_rvalid_i;
  assign issue = rest && free && (m0_req_i || m1_req_i);

  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    s_be_o    = '0;
    if (issue) begin
      s_req_o = 1'b1;
      if (win[1]) begin
        s_we_o    = m1_we_i;
        s_addr_o  = m1_addr_i;
        s_wdata_o = m1_wdata_i;
        s_be_o    = m1_be_i;
      end else begin
        s_addr_o  = m0_addr_i;
        s_be_o    = '1;
      end
    end
  end

  assign m0_gnt_o = issue && win[0] && s_gnt_i;
  assign m1_gnt_o = issue && win[1] && s_gnt_i;

  assign m0_rvalid_o = busy_m0 && s_rvalid_i;
  assign m1_rvalid_o = busy_m1 && s_rvalid_i;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

  // A grant taken in a response cycle overrides the return to IDLE.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state <= IDLE;
      last  <= M1;
    end else if (m0_gnt_o) begin
      state <= BUSY_M0;
      last  <= M0;
    end else if (m1_gnt_o) begin
      state <= BUSY_M1;
      last  <= M1;
    end else if (s_rvalid_i) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change 2ns after each rising
// edge and outputs are sampled 1ns later, well clear of the clock edges.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rest;
  logic        m0_req_i;
  logic [31:0] m0_addr_i;
  logic        m0_gnt_o;
  logic        m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [3:0]  m1_be_i;
  logic        m1_gnt_o;
  logic        m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic        s_req_o;
  logic        s_we_o;
  logic [31:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_be_o;
  logic        s_gnt_i;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rest        (rest),
    .m0_req_i    (m0_req_i),
    .m0_addr_i   (m0_addr_i),
    .m0_gnt_o    (m0_gnt_o),
    .m0_rvalid_o (m0_rvalid_o),
    .m0_rdata_o  (m0_rdata_o),
    .m1_req_i    (m1_req_i),
    .m1_we_i     (m1_we_i),
    .m1_addr_i   (m1_addr_i),
    .m1_wdata_i  (m1_wdata_i),
    .m1_be_i     (m1_be_i),
    .m1_gnt_o    (m1_gnt_o),
    .m1_rvalid_o (m1_rvalid_o),
    .m1_rdata_o  (m1_rdata_o),
    .s_req_o     (s_req_o),
    .s_we_o      (s_we_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_be_o      (s_be_o),
    .s_gnt_i     (s_gnt_i),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic r0, input logic [31:0] a0,
                               input logic r1, input logic we, input logic [31:0] a1,
                               input logic [31:0] wd, input logic [3:0] be,
                               input logic gnt, input logic rv, input logic [31:0] rd);
    m0_req_i   = r0;
    m0_addr_i  = a0;
    m1_req_i   = r1;
    m1_we_i    = we;
    m1_addr_i  = a1;
    m1_wdata_i = wd;
    m1_be_i    = be;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic exp_m1;
    rest = 1'b0;
    #2;

    $display("[TB] reset held with both masters requesting");
    applyStimulus(1, 32'h40, 1, 0, 32'h80, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("rst_m0_gnt", m0_gnt_o, 0);
    checkOutput("rst_m1_gnt", m1_gnt_o, 0);
    checkOutput("rst_s_req", s_req_o, 0);
    checkOutput("rst_s_addr", s_addr_o, 32'h0);
    checkOutput("rst_m0_rvalid", m0_rvalid_o, 0);
    checkOutput("rst_m1_rdata", m1_rdata_o, 32'h0);
    tick();
    tick();

    $display("[TB] first tie after reset goes to m0");
    rest = 1'b1;
    applyStimulus(1, 32'h40, 1, 0, 32'h80, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("first_m0_gnt", m0_gnt_o, 1);
    checkOutput("first_m1_gnt", m1_gnt_o, 0);
    checkOutput("first_s_addr", s_addr_o, 32'h40);
    checkOutput("first_s_be", s_be_o, 4'hF);
    checkOutput("first_s_we", s_we_o, 0);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h1234);
    checkOutput("first_m0_rvalid", m0_rvalid_o, 1);
    checkOutput("first_m0_rdata", m0_rdata_o, 32'h1234);
    checkOutput("first_m1_rvalid", m1_rvalid_o, 0);
    checkOutput("first_m1_rdata", m1_rdata_o, 32'h0);
    checkOutput("first_idle_s_req", s_req_o, 0);
    tick();

    $display("[TB] m1 write alone");
    applyStimulus(0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF, 4'b0011, 1, 0, 32'h0);
    checkOutput("wr_m1_gnt", m1_gnt_o, 1);
    checkOutput("wr_m0_gnt", m0_gnt_o, 0);
    checkOutput("wr_s_we", s_we_o, 1);
    checkOutput("wr_s_be", s_be_o, 4'b0011);
    checkOutput("wr_s_addr", s_addr_o, 32'h100);
    checkOutput("wr_s_wdata", s_wdata_o, 32'hDEADBEEF);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h0);
    checkOutput("wr_ack_m1_rvalid", m1_rvalid_o, 1);
    checkOutput("wr_ack_m0_rvalid", m0_rvalid_o, 0);
    tick();

    $display("[TB] both requesting against a 1-cycle memory");
    // Last winner was m1, so m0 takes the first tie and grants then alternate.
    exp_m1 = 1'b0;
    applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("rr0_m0_gnt", m0_gnt_o, 1);
    checkOutput("rr0_m1_gnt", m1_gnt_o, 0);
    tick();
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1, 32'h200, 1, 0, 32'h300, 32'h0, 4'hF, 1, 1,
                    exp_m1 ? 32'h300 : 32'h200);
      checkOutput($sformatf("rr%0d_m0_rvalid", i), m0_rvalid_o, !exp_m1);
      checkOutput($sformatf("rr%0d_m1_rvalid", i), m1_rvalid_o, exp_m1);
      checkOutput($sformatf("rr%0d_rdata", i), exp_m1 ? m1_rdata_o : m0_rdata_o,
                  exp_m1 ? 32'h300 : 32'h200);
      checkOutput($sformatf("rr%0d_m0_gnt", i), m0_gnt_o, exp_m1);
      checkOutput($sformatf("rr%0d_m1_gnt", i), m1_gnt_o, !exp_m1);
      checkOutput($sformatf("rr%0d_s_addr", i), s_addr_o, exp_m1 ? 32'h200 : 32'h300);
      exp_m1 = !exp_m1;
      tick();
    end
    // Four alternations from m0 leave an m0 access outstanding; drain it.
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h200);
    checkOutput("rr_drain_m0_rvalid", m0_rvalid_o, 1);
    checkOutput("rr_drain_m1_rvalid", m1_rvalid_o, 0);
    tick();

    $display("[TB] stall with s_gnt low, grant follows the pointer");
    // Last winner is m0, so m1 should win even though m0 arrived first.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h400, 0, 0, 32'h500, 32'h0, 4'hF, 0, 0, 32'h0);
      checkOutput($sformatf("stall%0d_m0_gnt", i), m0_gnt_o, 0);
      checkOutput($sformatf("stall%0d_s_req", i), s_req_o, 1);
      tick();
    end
    applyStimulus(1, 32'h400, 1, 0, 32'h500, 32'h0, 4'hF, 0, 0, 32'h0);
    checkOutput("stall_both_m0_gnt", m0_gnt_o, 0);
    checkOutput("stall_both_m1_gnt", m1_gnt_o, 0);
    checkOutput("stall_both_s_addr", s_addr_o, 32'h500);
    tick();
    applyStimulus(1, 32'h400, 1, 0, 32'h500, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("unstall_m1_gnt", m1_gnt_o, 1);
    checkOutput("unstall_m0_gnt", m0_gnt_o, 0);
    tick();

    $display("[TB] owner held off while busy, then grant in response cycle");
    applyStimulus(1, 32'h400, 1, 0, 32'h504, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("busy_m1_gnt", m1_gnt_o, 0);
    checkOutput("busy_m0_gnt", m0_gnt_o, 0);
    checkOutput("busy_s_req", s_req_o, 0);
    tick();
    applyStimulus(1, 32'h400, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hCAFE);
    checkOutput("resp_m1_rvalid", m1_rvalid_o, 1);
    checkOutput("resp_m1_rdata", m1_rdata_o, 32'hCAFE);
    checkOutput("resp_m0_rvalid", m0_rvalid_o, 0);
    checkOutput("resp_m0_gnt", m0_gnt_o, 1);
    tick();
    // Now BUSY_M0: its response must land on m0.
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'hBEEF);
    checkOutput("busy_m0_rvalid", m0_rvalid_o, 1);
    checkOutput("busy_m0_rdata", m0_rdata_o, 32'hBEEF);
    tick();

    $display("[TB] reset pulse drops the outstanding access");
    applyStimulus(1, 32'h600, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    checkOutput("pre_rst_m0_gnt", m0_gnt_o, 1);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h0);
    rest = 1'b0;
    #2;
    rest = 1'b1;
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h7777);
    checkOutput("stray_m0_rvalid", m0_rvalid_o, 0);
    checkOutput("stray_m1_rvalid", m1_rvalid_o, 0);
    checkOutput("stray_m0_rdata", m0_rdata_o, 32'h0);
    tick();
    // Still IDLE: a lone m1 request without any response must be granted.
    applyStimulus(0, 32'h0, 1, 0, 32'h700, 32'h0, 4'hF, 1, 0, 32'h0);
    checkOutput("post_rst_m1_gnt", m1_gnt_o, 1);
    checkOutput("post_rst_s_addr", s_addr_o, 32'h700);
    tick();
    applyStimulus(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 32'h55);
    checkOutput("post_rst_m1_rvalid", m1_rvalid_o, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave arbiter that shares the single-port data/instruction memory between the CPU's instruction-fetch unit (master 0) and the load/store unit (master 1). It sits inside `cpu_top`, between `cpu_core` and the memory. It grants one transaction at a time, tracks the single outstanding access, and routes the response back to its owner. When both masters request at once, round-robin fairness decides, so neither fetch nor data access can starve.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; byte-enable width is DW/8

Ports:
- `clk`  in  1  system clock, rising edge
- `rest`  in  1  asynchronous active-low reset
- `m0_req_i`  in  1  fetch request (read only)
- `m0_addr_i`  in  AW  fetch address
- `m0_gnt_o`  out  1  fetch request accepted this cycle
- `m0_rvalid_o`  out  1  fetch response valid
- `m0_rdata_o`  out  DW  fetch read data
- `m1_req_i`  in  1  data request
- `m1_we_i`  in  1  1 = write, 0 = read
- `m1_addr_i`  in  AW  data address
- `m1_wdata_i`  in  DW  write data
- `m1_be_i`  in  DW/8  byte enables
- `m1_gnt_o`  out  1  data request accepted
- `m1_rvalid_o`  out  1  data response (read data or write ack)
- `m1_rdata_o`  out  DW  data read data
- `s_req_o`, `s_we_o`, `s_addr_o`, `s_wdata_o`, `s_be_o`  out  1/1/AW/DW/DW/8  request to memory
- `s_gnt_i`  in  1  memory accepts request
- `s_rvalid_i`  in  1  memory response valid, for both reads and writes
- `s_rdata_i`  in  DW  memory read data

## Operation
- **FSM states:**
  - IDLE: no access outstanding.
  - BUSY_M0: fetch access outstanding.
  - BUSY_M1: data access outstanding.
- **Issue (IDLE, or BUSY_x in the same cycle as `s_rvalid_i`):**
  - The arbiter picks a winner among the asserted requests.
  - `s_*` is driven combinationally from the winner's request. Master 0 is forced to `s_we_o`=0, `s_be_o`=all ones, `s_wdata_o`=0.
  - `s_req_o`=1.
  - If `s_gnt_i`=1: `mX_gnt_o`=1, state → BUSY_X, and the last-winner pointer is updated.
  - If `s_gnt_i`=0: no grant, state unchanged. The arbitration decision is recomputed every cycle and is not latched.
- **Arbitration:**
  - A single requester always wins.
  - If both request, the master that was not granted last wins.
  - The pointer resets so that master 0 wins the first tie.
- **Response (BUSY_X with `s_rvalid_i`=1):**
  - `mX_rvalid_o`=1 and `mX_rdata_o`=`s_rdata_i`, routed combinationally.
  - The other master's rvalid stays 0.
  - The FSM returns to IDLE unless a new grant is taken in the same cycle.
- **Rdata when not valid:** `mX_rdata_o` is 0 whenever `mX_rvalid_o`=0.
- **Stray responses:** `s_rvalid_i` in IDLE is ignored; no master sees rvalid.
- **Reset mid-transaction:** asserting `rest` mid-transaction drops the outstanding access. Its late `s_rvalid_i` arrives in IDLE and is discarded.
- **Outstanding limit:** at most one outstanding access. A request from the owner while BUSY is held off until the response cycle.

## Timing
- **Reset values:**
  - state=IDLE, pointer=M1 (so M0 wins the first tie).
  - All `*_gnt_o`, `*_rvalid_o`, `s_req_o` = 0; all data outputs 0.
- **Grant latency:** 0 cycles. The grant is combinational in the cycle where req, `s_gnt_i` and a free slot coincide.
- **Response latency:** one memory latency; the arbiter adds no cycles.
- **Back-to-back throughput:** with a 1-cycle memory, one access per cycle, because the next grant is allowed in the response cycle.
- **Request stability:** masters hold req/addr/data stable until granted. The arbiter does not register request fields.
- **Combinational path:** `s_gnt_i`→`m*_gnt_o` is combinational. The memory must not derive `s_gnt_i` from `m*_gnt_o`.

## Structure
- **Shared package `bus_pkg`:**
  - State encoding: IDLE=2'd0, BUSY_M0=2'd1, BUSY_M1=2'd2.
  - Master IDs: M0=1'b0, M1=1'b1.
  - Default AW/DW.
- **Sub-module `rr_arb2`:** 2-input round-robin picker. Inputs: two request bits plus the last-winner pointer. Outputs: one-hot winner. Purely combinational; the pointer register lives in the parent.
- **Top module:** holds the FSM, the pointer, the request mux and the response demux.

## Test plan
- Reset with `rest`=0 while both reqs=1 → no gnt, no `s_req_o`. After `rest`=1 with `s_gnt_i`=1, m0 is granted first.
- m1 write alone: addr=0x100, wdata=0xDEADBEEF, be=4'b0011, `s_gnt_i`=1 → same cycle `s_we_o`=1, `s_be_o`=0011, `m1_gnt_o`=1. Ack cycle: `m1_rvalid_o`=1, `m0_rvalid_o`=0.
- Both requesting continuously, 1-cycle memory returning rdata=address → grants alternate M0, M1, M0, M1, one per cycle. Each rdata is routed to the correct master.
- `s_gnt_i`=0 for 3 cycles with m0 requesting, then m1 also requests → no gnt during the stall. On `s_gnt_i`=1, the grant follows the pointer, not the arrival order.
- m0 granted, `rest` pulsed before the response, then `s_rvalid_i`=1 in IDLE → neither rvalid asserts; state stays IDLE.
- BUSY_M1 with `s_rvalid_i`=1 while m0 requests → in the same cycle `m1_rvalid_o`=1 and `m0_gnt_o`=1; the next state is BUSY_M0.
